// File: rtl/parallel_in.sv
// Memory-mapped parallel input port: synchronizes an external byte/strobe pair,
// holds the byte until the CPU loads it from DATA_ADDR, and acknowledges the consume.
module parallel_in #(
    parameter int         WIDTH     = 8,
    parameter logic [7:0] DATA_ADDR = 8'hFF,
    parameter logic [7:0] STAT_ADDR = 8'hFE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       Address,
    input  logic             re,
    input  logic [WIDTH-1:0] MemData,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             StrobeIn,
    output logic             rden,
    output logic [WIDTH-1:0] ReadData,
    output logic             Ack
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_FULL    = 2'b01,
        ST_OVERRUN = 2'b10
    } state_t;

    state_t             state_r;
    logic               strobe_s1_r;
    logic               strobe_s2_r;
    logic               strobe_s3_r;
    logic [WIDTH-1:0]   data_s1_r;
    logic [WIDTH-1:0]   data_s2_r;
    logic [WIDTH-1:0]   cap_data_r;
    logic               ack_r;

    logic               is_data_s;
    logic               is_stat_s;
    logic               event_s;
    logic               consume_s;
    logic               valid_s;
    logic               overrun_s;
    logic [WIDTH-1:0]   status_s;
    logic [WIDTH-1:0]   read_data_s;

    assign is_data_s = (Address == DATA_ADDR);
    assign is_stat_s = (Address == STAT_ADDR);
    assign event_s   = strobe_s2_r & ~strobe_s3_r;
    assign consume_s = re & is_data_s & (state_r != ST_EMPTY);
    assign valid_s   = (state_r != ST_EMPTY);
    assign overrun_s = (state_r == ST_OVERRUN);
    assign status_s  = {{(WIDTH-2){1'b0}}, overrun_s, valid_s};

    // Two-flop synchronizer on strobe and data, plus edge-detect history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_s1_r <= 1'b0;
            strobe_s2_r <= 1'b0;
            strobe_s3_r <= 1'b0;
            data_s1_r   <= {WIDTH{1'b0}};
            data_s2_r   <= {WIDTH{1'b0}};
        end else begin
            strobe_s1_r <= StrobeIn;
            strobe_s2_r <= strobe_s1_r;
            strobe_s3_r <= strobe_s2_r;
            data_s1_r   <= DataIn;
            data_s2_r   <= data_s1_r;
        end
    end

    // Holding-register state machine with capture register and acknowledge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_EMPTY;
            cap_data_r <= {WIDTH{1'b0}};
            ack_r      <= 1'b0;
        end else begin
            ack_r <= consume_s;
            case (state_r)
                ST_EMPTY: begin
                    if (event_s) begin
                        state_r    <= ST_FULL;
                        cap_data_r <= data_s2_r;
                    end
                end
                ST_FULL: begin
                    // A consume and a new byte on the same edge hands over cleanly.
                    if (consume_s && event_s) begin
                        state_r    <= ST_FULL;
                        cap_data_r <= data_s2_r;
                    end else if (consume_s) begin
                        state_r <= ST_EMPTY;
                    end else if (event_s) begin
                        state_r <= ST_OVERRUN;
                    end
                end
                ST_OVERRUN: begin
                    if (consume_s) begin
                        state_r <= ST_EMPTY;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

    // Load-data mux: port registers override data memory at their addresses.
    always_comb begin
        read_data_s = MemData;
        if (is_data_s) begin
            read_data_s = cap_data_r;
        end else if (is_stat_s) begin
            read_data_s = status_s;
        end else begin
            read_data_s = MemData;
        end
    end

    assign ReadData = read_data_s;
    assign rden     = re & ~(is_data_s | is_stat_s);
    assign Ack      = ack_r;

endmodule

// File: tb/tb_parallel_in.sv
// Directed bench for parallel_in: expected values are queued when stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_parallel_in;

    logic       clk;
    logic       rst_n;
    logic [7:0] Address;
    logic       re;
    logic [7:0] MemData;
    logic [7:0] DataIn;
    logic       StrobeIn;
    logic       rden;
    logic [7:0] ReadData;
    logic       Ack;

    int         checks;
    int         errors;
    logic [7:0] exp_q[$];

    parallel_in dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Address  (Address),
        .re       (re),
        .MemData  (MemData),
        .DataIn   (DataIn),
        .StrobeIn (StrobeIn),
        .rden     (rden),
        .ReadData (ReadData),
        .Ack      (Ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h but no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    // One load cycle: data checked combinationally, then the edge that consumes it.
    task automatic load(input logic [7:0] addr, input logic [7:0] e, input string tag);
        Address = addr;
        re      = 1'b1;
        push(e);
        #1;
        check(tag, ReadData);
        step();
        re = 1'b0;
    endtask

    task automatic status_is(input logic [7:0] e, input string tag);
        Address = 8'hFE;
        push(e);
        #1;
        check(tag, ReadData);
    endtask

    task automatic ack_is(input logic e, input string tag);
        push({7'b0000000, e});
        #1;
        check(tag, {7'b0000000, Ack});
    endtask

    // Device presents a byte, holds the strobe 3 cycles, then idles 3 cycles.
    task automatic strobe_byte(input logic [7:0] b);
        DataIn   = b;
        StrobeIn = 1'b1;
        repeat (3) step();
        StrobeIn = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        re       = 1'b0;
        Address  = 8'h00;
        MemData  = 8'h5C;
        DataIn   = 8'h00;
        StrobeIn = 1'b0;

        // Reset state
        repeat (2) step();
        ack_is(1'b0, "rst_ack");
        status_is(8'h00, "rst_status");
        Address = 8'hFF;
        push(8'h00);
        #1;
        check("rst_data", ReadData);
        Address = 8'h10;
        re      = 1'b1;
        push(8'h01);
        push(8'h5C);
        #1;
        check("rst_rden_mem", {7'b0000000, rden});
        check("rst_memdata", ReadData);
        re = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (2) step();

        // Basic transfer with capture latency boundary
        DataIn   = 8'hA5;
        StrobeIn = 1'b1;
        Address  = 8'hFE;
        step();
        step();
        status_is(8'h00, "basic_not_yet_valid");
        step();
        status_is(8'h01, "basic_valid");
        StrobeIn = 1'b0;
        step();
        load(8'hFF, 8'hA5, "basic_data");
        ack_is(1'b1, "basic_ack_pulse");
        status_is(8'h00, "basic_empty_after");
        step();
        ack_is(1'b0, "basic_ack_low");
        repeat (2) step();

        // Overrun: second byte discarded
        strobe_byte(8'h11);
        status_is(8'h01, "ovr_first_valid");
        strobe_byte(8'h22);
        status_is(8'h03, "ovr_status");
        load(8'hFF, 8'h11, "ovr_old_byte");
        ack_is(1'b1, "ovr_ack");
        status_is(8'h00, "ovr_cleared");
        step();

        // Simultaneous event and consume
        strobe_byte(8'h33);
        DataIn   = 8'h44;
        StrobeIn = 1'b1;
        step();
        step();
        load(8'hFF, 8'h33, "simul_old_byte");
        StrobeIn = 1'b0;
        status_is(8'h01, "simul_still_full");
        ack_is(1'b1, "simul_ack");
        repeat (3) step();
        load(8'hFF, 8'h44, "simul_new_byte");
        status_is(8'h00, "simul_empty");
        step();

        // Memory isolation and empty reads
        Address = 8'hFF;
        re      = 1'b1;
        push(8'h00);
        #1;
        check("iso_rden_data", {7'b0000000, rden});
        Address = 8'hFE;
        push(8'h00);
        #1;
        check("iso_rden_stat", {7'b0000000, rden});
        Address = 8'h40;
        MemData = 8'hC3;
        push(8'h01);
        push(8'hC3);
        #1;
        check("iso_rden_mem", {7'b0000000, rden});
        check("iso_memdata", ReadData);
        re = 1'b0;
        load(8'hFF, 8'h44, "empty_read_last_byte");
        ack_is(1'b0, "empty_read_no_ack");
        strobe_byte(8'h77);
        Address = 8'hFF;
        re      = 1'b0;
        repeat (2) step();
        ack_is(1'b0, "store_no_ack");
        status_is(8'h01, "store_no_consume");
        load(8'hFF, 8'h77, "store_then_load");
        step();

        // Asynchronous reset mid-operation
        strobe_byte(8'h5A);
        status_is(8'h01, "arst_full");
        #1;
        rst_n = 1'b0;
        #1;
        status_is(8'h00, "arst_status");
        ack_is(1'b0, "arst_ack");
        Address = 8'hFF;
        push(8'h00);
        #1;
        check("arst_data", ReadData);
        step();
        rst_n = 1'b1;
        repeat (2) step();

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d leftover expected values, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
